csi2_dev_elastbuf_reader: RTL and testbench

- Read-side controller for the device elastic buffer, sitting between the buffer and the packet-layer consumer.
- Drains 32-bit words from the buffer and frames them into one packet of a given CSI-2 word count (WC, in bytes).
- Presents the words on a valid/ready stream with byte enables and a last flag.
- Signals completion, and issues the buffer's synchronous clear on abort.

---
 rtl/csi2_dev_pkg.sv | 25 ++
 rtl/csi2_dev_crc16_byte.sv | 19 +
 rtl/csi2_dev_elastbuf_reader.sv | 140 ++++++++++++++
 tb/tb_csi2_dev_elastbuf_reader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_dev_pkg.sv
// Shared types and constants for the CSI-2 device elastic-buffer read path.
// Holds the reader state encoding, CRC-16 constants and the byte-enable helper.
package csi2_dev_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } rd_state_e;

  // x^16+x^12+x^5+1 in reflected (LSB-first) form
  localparam logic [15:0] CRC16_POLY_REFL = 16'h8408;
  localparam logic [15:0] CRC16_SEED      = 16'hFFFF;

  localparam int MAX_BYTES = 64;

  // LSB-first contiguous enables for 'cnt' remaining bytes; caller slices to its width,
  // so any cnt >= word size yields all ones.
  function automatic logic [MAX_BYTES-1:0] be_from_count(input logic [31:0] cnt);
    logic [MAX_BYTES-1:0] be;
    for (int i = 0; i < MAX_BYTES; i++) be[i] = (32'(i) < cnt);
    return be;
  endfunction

endpackage

// File: rtl/csi2_dev_crc16_byte.sv
// One-byte CSI-2 CRC-16 update (reflected, LSB first); passes crc through when en_i=0.
module csi2_dev_crc16_byte
  import csi2_dev_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  input  logic        en_i,
  output logic [15:0] crc_o
);

  logic [15:0] c;

  always_comb begin
    c = crc_i ^ {8'h00, data_i};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
    crc_o = en_i ? c : crc_i;
  end

endmodule

// File: rtl/csi2_dev_elastbuf_reader.sv
// Elastic-buffer read controller: frames one packet of pkt_wc bytes into a valid/ready word stream.
// Optional CRC-16 over delivered bytes when CSI2_ELASTBUF_RD_CRC_EN is defined (adds crc_out).
module csi2_dev_elastbuf_reader
  import csi2_dev_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WC_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rstz,
  input  logic                    pkt_start,
  input  logic [WC_WIDTH-1:0]     pkt_wc,
  input  logic                    abort,
  input  logic                    buf_emptyz,
  input  logic [DATA_WIDTH-1:0]   buf_dataout,
  output logic                    buf_read,
  output logic                    buf_clrbuff,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [DATA_WIDTH/8-1:0] out_be,
  output logic                    out_last,
  output logic                    pkt_done,
  output logic                    busy
`ifdef CSI2_ELASTBUF_RD_CRC_EN
  ,
  output logic [15:0]             crc_out
`endif
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [WC_WIDTH-1:0] BYTES_W = WC_WIDTH'(BYTES);

  rd_state_e             state_q;
  logic [WC_WIDTH-1:0]   bytes_left_q, bytes_left_d;
  logic                  out_valid_q, out_last_q, pkt_done_q, clr_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [BYTES-1:0]      out_be_q, out_be_d;
  logic [MAX_BYTES-1:0]  be_full;
  logic                  last_word, hs, pop;

  assign hs        = out_valid_q & out_ready;
  assign last_word = (bytes_left_q <= BYTES_W);
  // Abort blocks the pop so the buffer is never advanced in the cycle it is being cleared.
  assign pop = (state_q == ST_ACTIVE) & buf_emptyz & (bytes_left_q != '0) &
               (~out_valid_q | out_ready) & ~abort;

  always_comb begin
    be_full      = be_from_count(32'(bytes_left_q));
    out_be_d     = be_full[BYTES-1:0];
    bytes_left_d = last_word ? '0 : (bytes_left_q - BYTES_W);
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q      <= ST_IDLE;
      bytes_left_q <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      out_be_q     <= '0;
      pkt_done_q   <= 1'b0;
      clr_q        <= 1'b0;
    end else if (abort) begin
      state_q      <= ST_IDLE;
      bytes_left_q <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      pkt_done_q   <= 1'b0;
      clr_q        <= 1'b1;
    end else begin
      clr_q      <= 1'b0;
      pkt_done_q <= 1'b0;
      if (pop) begin
        out_data_q   <= buf_dataout;
        out_valid_q  <= 1'b1;
        out_last_q   <= last_word;
        out_be_q     <= out_be_d;
        bytes_left_q <= bytes_left_d;
      end else if (hs) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (pkt_start) begin
            if (pkt_wc != '0) begin
              bytes_left_q <= pkt_wc;
              state_q      <= ST_ACTIVE;
            end else begin
              pkt_done_q <= 1'b1;
            end
          end
        end
        ST_ACTIVE: if (pop && last_word) state_q <= ST_DRAIN;
        ST_DRAIN: begin
          if (hs && out_last_q) begin
            state_q    <= ST_IDLE;
            pkt_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign buf_read    = pop;
  assign buf_clrbuff = clr_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_be      = out_be_q;
  assign out_last    = out_last_q;
  assign pkt_done    = pkt_done_q;
  assign busy        = (state_q != ST_IDLE);

`ifdef CSI2_ELASTBUF_RD_CRC_EN
  logic [BYTES:0][15:0] crc_chain;
  logic [15:0]          crc_q;

  assign crc_chain[0] = crc_q;

  for (genvar g = 0; g < BYTES; g++) begin : g_crc
    csi2_dev_crc16_byte u_crc (
      .crc_i  (crc_chain[g]),
      .data_i (out_data_q[8*g +: 8]),
      .en_i   (out_be_q[g]),
      .crc_o  (crc_chain[g+1])
    );
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz)                                        crc_q <= CRC16_SEED;
    else if (abort || (state_q == ST_IDLE && pkt_start)) crc_q <= CRC16_SEED;
    else if (hs)                                      crc_q <= crc_chain[BYTES];
  end

  assign crc_out = crc_q;
`endif

endmodule

// File: tb/tb_csi2_dev_elastbuf_reader.sv
// Scoreboard bench for csi2_dev_elastbuf_reader: randomized packets, buffer model, decoupled monitor.
module tb_csi2_dev_elastbuf_reader;
  localparam int DW = 32;
  localparam int WCW = 16;
  localparam int BY = DW / 8;

  logic           clk = 1'b0;
  logic           rstz = 1'b0;
  logic           pkt_start = 1'b0;
  logic [WCW-1:0] pkt_wc = '0;
  logic           abort = 1'b0;
  logic           buf_emptyz = 1'b0;
  logic [DW-1:0]  buf_dataout = '0;
  logic           out_ready = 1'b0;
  wire            buf_read, buf_clrbuff, out_valid, out_last, pkt_done, busy;
  wire [DW-1:0]   out_data;
  wire [BY-1:0]   out_be;
`ifdef CSI2_ELASTBUF_RD_CRC_EN
  wire [15:0]     crc_out;
`endif

  csi2_dev_elastbuf_reader #(.DATA_WIDTH(DW), .WC_WIDTH(WCW)) dut (
    .clk(clk), .rstz(rstz), .pkt_start(pkt_start), .pkt_wc(pkt_wc), .abort(abort),
    .buf_emptyz(buf_emptyz), .buf_dataout(buf_dataout), .buf_read(buf_read),
    .buf_clrbuff(buf_clrbuff), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_be(out_be), .out_last(out_last), .pkt_done(pkt_done),
    .busy(busy)
`ifdef CSI2_ELASTBUF_RD_CRC_EN
    , .crc_out(crc_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [BY-1:0] be;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] bq[$];
  logic [15:0]   crc_exp[$];
  int checks = 0, errors = 0;
  int avail_pct = 100, ready_pct = 100, ready_hold = 0;
  int rd_cnt = 0, clr_cnt = 0;
  logic rd_s = 1'b0, clr_s = 1'b0, tb_idle = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Buffer + consumer model: pops/clears on the edge, then presents new head and randomized ready.
  always @(posedge clk) begin
    if (clr_s) bq.delete();
    else if (rd_s && bq.size() > 0) void'(bq.pop_front());
    #3;
    buf_emptyz  = (bq.size() > 0) && ($urandom_range(0, 99) < avail_pct);
    buf_dataout = (bq.size() > 0) ? bq[0] : '0;
    out_ready   = (ready_hold > 0) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
    if (ready_hold > 0) ready_hold--;
  end

  logic done_pend = 0, clr_pend = 0, abort_prev = 0, stall_prev = 0;
  logic [DW-1:0] st_d;
  logic [BY-1:0] st_be;
  logic st_last;
  exp_t e_m;

  always @(negedge clk) begin
    rd_s  = buf_read;
    clr_s = buf_clrbuff;
    if (rstz) begin
      rd_cnt  += int'(buf_read);
      clr_cnt += int'(buf_clrbuff);
      chk("busy", busy, !tb_idle);
      if (pkt_done || done_pend) chk("pkt_done", pkt_done, done_pend);
`ifdef CSI2_ELASTBUF_RD_CRC_EN
      if (done_pend) begin
        if (crc_exp.size() > 0) chk("crc_out", crc_out, crc_exp.pop_front());
        else chk("crc_expectation_present", 0, 1);
      end
`endif
      if (buf_clrbuff || clr_pend) chk("buf_clrbuff", buf_clrbuff, clr_pend);
      if (abort_prev) chk("out_valid_after_abort", out_valid, 0);
      if (buf_read) begin
        chk("read_nonempty", buf_emptyz, 1);
        chk("read_while_stalled", out_valid && !out_ready, 0);
      end
      if (abort) chk("read_in_abort", buf_read, 0);
      if (stall_prev && !abort_prev)
        chk("stall_hold", {out_valid, out_last, out_be, out_data}, {1'b1, st_last, st_be, st_d});
      done_pend = 1'b0;
      clr_pend  = abort;
      if (abort) begin
        exp_q.delete();
        crc_exp.delete();
        tb_idle = 1'b1;
      end else begin
        if (pkt_start && tb_idle) begin
          if (pkt_wc == '0) done_pend = 1'b1;
          else tb_idle = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word: got %0h expected no word at %0t", out_data, $time);
          end else begin
            e_m = exp_q.pop_front();
            chk("data", out_data, e_m.d);
            chk("be", out_be, e_m.be);
            chk("last", out_last, e_m.last);
            if (e_m.last) begin
              done_pend = 1'b1;
              tb_idle   = 1'b1;
            end
          end
        end
      end
      stall_prev = out_valid && !out_ready && !abort;
      st_d = out_data; st_be = out_be; st_last = out_last;
      abort_prev = abort;
    end else begin
      done_pend = 0; clr_pend = 0; abort_prev = 0; stall_prev = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(tb_idle && exp_q.size() == 0 && !busy) && t < 3000) begin
      tick(1);
      t++;
    end
    if (t >= 3000) chk("idle_timeout", 1, 0);
  endtask

  // Reference: ceil(wc/BY) words, enables from remaining bytes, CRC over bytes LSB-first.
  task automatic send(input int wc, input bit stray, input bit fixed);
    int n, rem;
    logic [DW-1:0] w;
    logic [BY-1:0] be;
    logic [15:0] c;
    logic fb;
    wait_idle();
    n = (wc + BY - 1) / BY;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      w   = fixed ? 32'h0403_0201 : $urandom;
      rem = wc - BY * i;
      be  = (rem >= BY) ? {BY{1'b1}} : BY'((1 << rem) - 1);
      exp_q.push_back('{d: w, be: be, last: (i == n - 1)});
      bq.push_back(w);
      for (int b = 0; b < BY && b < rem; b++)
        for (int k = 0; k < 8; k++) begin
          fb = c[0] ^ w[8*b + k];
          c  = c >> 1;
          if (fb) c = c ^ 16'h8408;
        end
    end
`ifdef CSI2_ELASTBUF_RD_CRC_EN
    crc_exp.push_back(c);
`endif
    pkt_start = 1'b1; pkt_wc = WCW'(wc);
    tick(1);
    pkt_start = 1'b0;
    if (stray && wc > 0) begin
      pkt_start = 1'b1; pkt_wc = '0;
      tick(1);
      pkt_start = 1'b0;
    end
  endtask

  initial begin
    int r0, c0, t;
    tick(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_be", out_be, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_clrbuff", buf_clrbuff, 0);
    chk("rst_busy", busy, 0);
    chk("rst_buf_read", buf_read, 0);
    rstz = 1'b1;
    tick(2);

    r0 = rd_cnt;
    send(8, 0, 0);
    wait_idle(); tick(2);
    chk("wc8_reads", rd_cnt - r0, 2);

    avail_pct = 30;
    send(5, 0, 0);
    wait_idle();

    avail_pct = 100;
    send(12, 0, 0);
    t = 0;
    while (!out_valid && t < 50) begin tick(1); t++; end
    ready_hold = 4;
    wait_idle();

    r0 = rd_cnt;
    send(0, 0, 0);
    tick(3);
    chk("wc0_reads", rd_cnt - r0, 0);

    c0 = clr_cnt;
    send(16, 0, 0);
    tick(1);
    abort = 1'b1; tick(1); abort = 1'b0;
    tick(4);
    chk("abort_clr_pulses", clr_cnt - c0, 1);
    send(4, 0, 0);
    wait_idle();

    c0 = clr_cnt;
    abort = 1'b1; pkt_start = 1'b1; pkt_wc = 16'd8;
    tick(1);
    abort = 1'b0; pkt_start = 1'b0;
    tick(3);
    chk("abort_start_clr", clr_cnt - c0, 1);

    send(40, 0, 0);
    tick(3);
    rstz = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_last", out_last, 0);
    exp_q.delete(); bq.delete(); crc_exp.delete(); tb_idle = 1'b1;
    tick(2);
    rstz = 1'b1;
    tick(2);

    send(4, 0, 1);
    wait_idle(); tick(2);
    send(0, 0, 0);
    tick(3);

    repeat (25) begin
      avail_pct = $urandom_range(20, 100);
      ready_pct = $urandom_range(20, 100);
      send($urandom_range(0, 40), 1'($urandom_range(0, 1)), 0);
    end
    wait_idle();
    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
